// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined segmented ripple-carry add/subtract unit
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands through STAGES pipeline segments.
//   Each segment is a SEG-bit chain of full-adder cells. The carry between
//   segments is registered. Upper operand segments ride along in skew
//   registers. Finished lower result segments ride along in deskew registers,
//   so every segment of a result leaves on the same cycle.
//
//   Latency is STAGES register ranks. Throughput is one operation per
//   non-hold cycle.
//
// Parameters:
//   WIDTH   operand/result width (>= 2)
//   STAGES  segment count and pipeline depth (>= 1); WIDTH % STAGES == 0
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; clears every pipeline register
//   valid_in   operands and mode are to be processed this cycle
//   a_in       operand A
//   b_in       operand B
//   c_in       carry-in (add) / borrow-in (subtract)
//   sub_in     0 = add, 1 = subtract
//   hold_in    freezes every register while high
//   sum        result
//   carry      raw carry out of the MSB (0 = borrow in subtract mode)
//   overflow   two's-complement signed overflow
//   valid_out  sum/carry/overflow carry a new result this cycle

module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  input  logic             hold_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             valid_out
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One segment: a ripple chain of full-adder cells.
  // The result is {carry_out, sum[SEG-1:0]}.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           ci);
    logic [SEG-1:0] s;
    logic           c;
    c = ci;
    s = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // Inputs seen by stage k. Index 0 is fed from the ports. Index k > 0 is fed
  // from the rank register that sits in front of stage k.
  logic [WIDTH-1:0] stg_a [STAGES];
  logic [WIDTH-1:0] stg_b [STAGES];
  logic [WIDTH-1:0] stg_s [STAGES];  // partial sum: segments below k are final
  logic             stg_c [STAGES];
  logic             stg_v [STAGES];

  // Outputs of stage k: the partial sum with segment k filled in, and that
  // segment's carry out.
  logic [WIDTH-1:0] sum_d  [STAGES];
  logic             cout_d [STAGES];

  // Subtract is a + ~b + ~c_in. The borrow-in sense is inverted so that
  // c_in = 1 removes one more from the result.
  assign stg_a[0] = a_in;
  assign stg_b[0] = sub_in ? ~b_in : b_in;
  assign stg_c[0] = sub_in ? ~c_in : c_in;
  assign stg_s[0] = '0;
  assign stg_v[0] = valid_in;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG:0]     seg_res;
      logic [WIDTH-1:0] part_sum;

      assign seg_res = seg_add(stg_a[k][k*SEG +: SEG],
                               stg_b[k][k*SEG +: SEG],
                               stg_c[k]);

      always_comb begin
        part_sum                = stg_s[k];
        part_sum[k*SEG +: SEG]  = seg_res[SEG-1:0];
      end

      assign sum_d[k]  = part_sum;
      assign cout_d[k] = seg_res[SEG];
    end

    // Rank registers between segments. Each rank carries the full operand
    // words; bits already consumed are never read again and are pruned by
    // synthesis. Data loads only behind a valid operation, so bubbles leave
    // the previous contents in place.
    for (k = 1; k < STAGES; k++) begin : g_rank
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (!hold_in) begin
          v_q <= stg_v[k-1];
          if (stg_v[k-1]) begin
            a_q <= stg_a[k-1];
            b_q <= stg_b[k-1];
            s_q <= sum_d[k-1];
            c_q <= cout_d[k-1];
          end
        end
      end

      assign stg_a[k] = a_q;
      assign stg_b[k] = b_q;
      assign stg_s[k] = s_q;
      assign stg_c[k] = c_q;
      assign stg_v[k] = v_q;
    end
  endgenerate

  // Signed overflow is resolved in the last segment. The operand MSBs used
  // here are the skewed copies that travelled with the operation.
  logic overflow_d;
  assign overflow_d = (stg_a[LAST][WIDTH-1] == stg_b[LAST][WIDTH-1]) &&
                      (sum_d[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             overflow_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!hold_in) begin
      valid_q <= stg_v[LAST];
      if (stg_v[LAST]) begin
        sum_q      <= sum_d[LAST];
        carry_q    <= cout_d[LAST];
        overflow_q <= overflow_d;
      end
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed self-checking bench for pipelined_addsub

module tb_pipelined_addsub;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       c_in;
  logic       sub_in;
  logic       hold_in;
  logic [7:0] sum;
  logic       carry;
  logic       overflow;
  logic       valid_out;

  int n_cmp;
  int n_err;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .sub_in    (sub_in),
    .hold_in   (hold_in),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] es, input logic ec,
                           input logic eo, input logic ev);
    check_val({tag, ".sum"},       {24'd0, sum},       {24'd0, es});
    check_val({tag, ".carry"},     {31'd0, carry},     {31'd0, ec});
    check_val({tag, ".overflow"},  {31'd0, overflow},  {31'd0, eo});
    check_val({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, ev});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input logic h);
    valid_in = v;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    sub_in   = s;
    hold_in  = h;
  endtask

  task automatic drive_idle();
    drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Issue one operation, then check: nothing after one edge, the result after
  // the second edge, and the result held with valid_out low after the third.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s, input logic [7:0] es,
                        input logic ec, input logic eo);
    drive(1'b1, a, b, c, s, 1'b0);
    tick();
    check_val({tag, ".lat1_valid"}, {31'd0, valid_out}, 32'd0);
    drive_idle();
    tick();
    check_out(tag, es, ec, eo, 1'b1);
    tick();
    check_out({tag, ".after"}, es, ec, eo, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // 1: reset with random operands and valid_in high
    tick();
    check_out("rst_c1", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    tick();
    check_out("rst_c2", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 2: inter-segment carry, carry out of the MSB
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: signed overflow, including via carry-in
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_7f_00_c1", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);

    // 4: subtract, borrow, signed overflow, borrow-in
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub_10_01_b1", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

    // 5: back-to-back stream with a two-cycle hold after the second input
    drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("strm_e1", 8'h0E, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("strm_r1", 8'h03, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h55, 8'h11, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("strm_hold1", 8'h03, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("strm_hold2", 8'h03, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("strm_r2", 8'h30, 1'b0, 1'b0, 1'b1);
    drive_idle();
    tick();
    check_out("strm_r3", 8'h10, 1'b1, 1'b0, 1'b1);
    drive_idle();
    tick();
    check_out("strm_end", 8'h10, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("strm_no_extra", 8'h10, 1'b1, 1'b0, 1'b0);

    // 6: reset discards in-flight operations
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("flush_e1.valid_out", {31'd0, valid_out}, 32'd0);
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_out("flush_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive_idle();
    tick();
    check_out("flush_c1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("flush_c2", 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("post_rst", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
